// File: rtl/operand_fwd_stage_pkg.sv
// Shared types and defaults for the operand forwarding stage.
// Imported by the forwarding selector and the stage top.
package operand_fwd_stage_pkg;

    localparam int XLEN_D = 32;
    localparam int RAW_D  = 5;

    typedef enum logic [1:0] {
        RF2SRC0   = 2'd0,
        PC2SRC0   = 2'd1,
        ZERO2SRC0 = 2'd2
    } src0sel_t;

    typedef enum logic {
        RF2SRC1 = 1'b0,
        IMM2SRC1 = 1'b1
    } src1sel_t;

endpackage

// File: rtl/operand_fwd_stage_fwd_sel.sv
// Priority forwarding match for one operand read port.
// Lowest port index is youngest and wins; reg 0 is never forwarded.
module operand_fwd_stage_fwd_sel
    import operand_fwd_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_D,
    parameter int RAW     = RAW_D,
    parameter int NUM_FWD = 3
) (
    input  logic [RAW-1:0]          addr,
    input  logic [XLEN-1:0]         p,
    input  logic [NUM_FWD-1:0]      fwd_vld,
    input  logic [NUM_FWD-1:0]      fwd_pend,
    input  logic [NUM_FWD*RAW-1:0]  fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]         data,
    output logic                    pend
);

    // Walk oldest to youngest so the youngest match is written last.
    always_comb begin
        data = p;
        pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_vld[i] && (fwd_addr[i*RAW +: RAW] == addr)
                && (addr != '0)) begin
                data = fwd_data[i*XLEN +: XLEN];
                pend = fwd_pend[i];
            end
        end
    end

endmodule

// File: rtl/operand_fwd_stage.sv
// Decode->execute operand stage: source select with forwarding,
// load-use hazard detection and a valid/ready ID/EX register.
module operand_fwd_stage
    import operand_fwd_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_D,
    parameter int RAW     = RAW_D,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  src0sel_t                src0sel,
    input  src1sel_t                src1sel,
    input  logic [RAW-1:0]          rs0_addr,
    input  logic [RAW-1:0]          rs1_addr,
    input  logic [XLEN-1:0]         p0,
    input  logic [XLEN-1:0]         p1,
    input  logic [XLEN-1:0]         pc,
    input  logic [XLEN-1:0]         imm,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [NUM_FWD-1:0]      fwd_vld,
    input  logic [NUM_FWD-1:0]      fwd_pend,
    input  logic [NUM_FWD*RAW-1:0]  fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic                    flush,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [XLEN-1:0]         src0_q,
    output logic [XLEN-1:0]         src1_q,
    output logic                    hazard,
    output logic [CNT_W-1:0]        stall_cnt,
    input  logic                    cnt_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] fwd0;
    logic [XLEN-1:0] fwd1;
    logic            pend0;
    logic            pend1;
    logic [XLEN-1:0] src0;
    logic [XLEN-1:0] src1;
    logic            use0;
    logic            use1;
    logic            load;

    operand_fwd_stage_fwd_sel #(
        .XLEN    (XLEN),
        .RAW     (RAW),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_sel0 (
        .addr     (rs0_addr),
        .p        (p0),
        .fwd_vld  (fwd_vld),
        .fwd_pend (fwd_pend),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .data     (fwd0),
        .pend     (pend0)
    );

    operand_fwd_stage_fwd_sel #(
        .XLEN    (XLEN),
        .RAW     (RAW),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_sel1 (
        .addr     (rs1_addr),
        .p        (p1),
        .fwd_vld  (fwd_vld),
        .fwd_pend (fwd_pend),
        .fwd_addr (fwd_addr),
        .fwd_data (fwd_data),
        .data     (fwd1),
        .pend     (pend1)
    );

    assign use0 = (src0sel == RF2SRC0);
    assign use1 = (src1sel == RF2SRC1);

    always_comb begin
        src0 = '0;
        unique case (src0sel)
            RF2SRC0: src0 = fwd0;
            PC2SRC0: src0 = pc;
            default: src0 = '0;
        endcase
    end

    assign src1   = use1 ? fwd1 : imm;
    assign hazard = in_vld & ((use0 & pend0) | (use1 & pend1));
    assign in_rdy = flush | (~hazard & (~out_vld | out_rdy));
    assign load   = in_vld & in_rdy & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            src0_q  <= '0;
            src1_q  <= '0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (load) begin
            out_vld <= 1'b1;
            src0_q  <= src0;
            src1_q  <= src1;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Scoreboard bench for operand_fwd_stage (CNT_W=2 to reach saturation).
// Expected operands are queued on acceptance and checked on consumption.
module tb_operand_fwd_stage;
    import operand_fwd_stage_pkg::*;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int NF   = 3;
    localparam int CW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    src0sel_t          src0sel;
    src1sel_t          src1sel;
    logic [RAW-1:0]    rs0_addr;
    logic [RAW-1:0]    rs1_addr;
    logic [XLEN-1:0]   p0;
    logic [XLEN-1:0]   p1;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic              in_vld;
    logic              in_rdy;
    logic [NF-1:0]     fwd_vld;
    logic [NF-1:0]     fwd_pend;
    logic [NF*RAW-1:0] fwd_addr;
    logic [NF*XLEN-1:0] fwd_data;
    logic              flush;
    logic              out_vld;
    logic              out_rdy;
    logic [XLEN-1:0]   src0_q;
    logic [XLEN-1:0]   src1_q;
    logic              hazard;
    logic [CW-1:0]     stall_cnt;
    logic              cnt_clr;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    bit          m_vld;
    logic [CW-1:0] m_cnt;

    operand_fwd_stage #(
        .XLEN    (XLEN),
        .RAW     (RAW),
        .NUM_FWD (NF),
        .CNT_W   (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src0sel   (src0sel),
        .src1sel   (src1sel),
        .rs0_addr  (rs0_addr),
        .rs1_addr  (rs1_addr),
        .p0        (p0),
        .p1        (p1),
        .pc        (pc),
        .imm       (imm),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .fwd_vld   (fwd_vld),
        .fwd_pend  (fwd_pend),
        .fwd_addr  (fwd_addr),
        .fwd_data  (fwd_data),
        .flush     (flush),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .src0_q    (src0_q),
        .src1_q    (src1_q),
        .hazard    (hazard),
        .stall_cnt (stall_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_fwd(input int i, input bit v, input bit pd,
                           input logic [RAW-1:0] a, input logic [XLEN-1:0] d);
        fwd_vld[i]             = v;
        fwd_pend[i]            = pd;
        fwd_addr[i*RAW +: RAW] = a;
        fwd_data[i*XLEN +: XLEN] = d;
    endtask

    // Called right after a negedge with inputs already driven.
    task automatic tick(input string tag, input bit ehz,
                        input logic [XLEN-1:0] e0, input logic [XLEN-1:0] e1);
        bit er;
        logic [63:0] f;
        #1;
        er = flush || (!ehz && (!m_vld || out_rdy));
        chk({tag, "_hz"}, 64'(hazard), 64'(ehz));
        chk({tag, "_rdy"}, 64'(in_rdy), 64'(er));
        chk({tag, "_vld"}, 64'(out_vld), 64'(m_vld));
        chk({tag, "_cnt"}, 64'(stall_cnt), 64'(m_cnt));
        if (m_vld && (out_rdy || flush)) begin
            chk({tag, "_sbsz"}, 64'(sb.size()), 64'd1);
            if (sb.size() > 0) begin
                f = sb.pop_front();
                if (out_rdy) begin
                    chk({tag, "_s0"}, 64'(src0_q), 64'(f[63:32]));
                    chk({tag, "_s1"}, 64'(src1_q), 64'(f[31:0]));
                end
            end
        end
        if (in_vld && er && !flush) begin
            sb.push_back({e0, e1});
            m_vld = 1'b1;
        end else if (flush || out_rdy) begin
            m_vld = 1'b0;
        end
        if (cnt_clr) m_cnt = '0;
        else if (in_vld && ehz && !flush && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        src0sel  = RF2SRC0;
        src1sel  = IMM2SRC1;
        rs0_addr = '0;
        rs1_addr = '0;
        p0       = '0;
        p1       = '0;
        pc       = '0;
        imm      = '0;
        in_vld   = 1'b1;
        fwd_vld  = '0;
        fwd_pend = '0;
        fwd_addr = '0;
        fwd_data = '0;
        flush    = 1'b0;
        out_rdy  = 1'b1;
        cnt_clr  = 1'b0;
        m_vld    = 1'b0;
        m_cnt    = '0;

        // reset held two cycles with in_vld high
        @(negedge clk);
        @(negedge clk);
        chk("rst_vld", 64'(out_vld), 64'd0);
        chk("rst_s0", 64'(src0_q), 64'd0);
        chk("rst_s1", 64'(src1_q), 64'd0);
        chk("rst_cnt", 64'(stall_cnt), 64'd0);
        rst_n  = 1'b1;
        in_vld = 1'b0;
        tick("idle", 0, 0, 0);

        // forwarding priority
        in_vld   = 1'b1;
        rs0_addr = 5'd5;
        p0       = 32'h1111;
        imm      = 32'h22;
        set_fwd(0, 1, 0, 5'd5, 32'hAAAA);
        set_fwd(2, 1, 0, 5'd5, 32'hCCCC);
        tick("pri0", 0, 32'hAAAA, 32'h22);
        set_fwd(0, 0, 0, 5'd5, 32'hAAAA);
        tick("pri2", 0, 32'hCCCC, 32'h22);
        set_fwd(2, 0, 0, 5'd5, 32'hCCCC);
        set_fwd(1, 1, 0, 5'd6, 32'hBBBB);
        tick("nomatch", 0, 32'h1111, 32'h22);

        // reg 0 and non-RF selectors
        rs0_addr = 5'd0;
        p0       = 32'h0;
        set_fwd(0, 1, 0, 5'd0, 32'hFFFF);
        tick("reg0", 0, 32'h0, 32'h22);
        src0sel  = PC2SRC0;
        pc       = 32'h100;
        rs0_addr = 5'd5;
        set_fwd(0, 1, 0, 5'd5, 32'hFFFF);
        tick("pcsel", 0, 32'h100, 32'h22);
        src0sel  = ZERO2SRC0;
        rs1_addr = 5'd5;
        imm      = 32'h33;
        tick("zero_imm", 0, 32'h0, 32'h33);

        // load-use hazard on src1
        set_fwd(0, 1, 1, 5'd7, 32'h7777);
        rs1_addr = 5'd7;
        p1       = 32'h1;
        src1sel  = RF2SRC1;
        for (int i = 0; i < 3; i++) tick("lu", 1, 0, 0);
        set_fwd(0, 1, 0, 5'd7, 32'h7777);
        tick("lu_done", 0, 32'h0, 32'h7777);
        set_fwd(0, 1, 1, 5'd7, 32'h7777);
        src1sel = IMM2SRC1;
        imm     = 32'h44;
        tick("lu_imm", 0, 32'h0, 32'h44);
        src1sel = RF2SRC1;
        set_fwd(0, 1, 0, 5'd7, 32'h5A5A);
        set_fwd(1, 1, 1, 5'd7, 32'h9999);
        tick("shadow", 0, 32'h0, 32'h5A5A);
        set_fwd(0, 0, 0, 5'd0, 32'h0);
        set_fwd(1, 0, 0, 5'd0, 32'h0);

        // back-pressure then full throughput
        in_vld = 1'b0;
        tick("drain", 0, 0, 0);
        in_vld  = 1'b1;
        out_rdy = 1'b0;
        p1      = 32'hA1;
        tick("bp_load", 0, 32'h0, 32'hA1);
        for (int i = 0; i < 3; i++) begin
            p1 = 32'hB0 + 32'(i);
            tick("bp_hold", 0, 32'h0, p1);
        end
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            p1 = 32'hC0 + 32'(i);
            tick("thru", 0, 32'h0, p1);
        end
        in_vld = 1'b0;
        tick("thru_drain", 0, 0, 0);

        // flush kills stage and discards incoming
        in_vld  = 1'b1;
        out_rdy = 1'b0;
        p1      = 32'hE1;
        tick("fl_load", 0, 32'h0, 32'hE1);
        flush = 1'b1;
        p1    = 32'hF1;
        tick("flush", 0, 32'h0, 32'hF1);
        flush   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        tick("post_fl", 0, 0, 0);

        // flush masks stall counting; saturation and clear priority
        in_vld  = 1'b1;
        set_fwd(0, 1, 1, 5'd7, 32'h7777);
        flush = 1'b1;
        tick("fl_hz", 1, 0, 0);
        flush = 1'b0;
        for (int i = 0; i < 5; i++) tick("sat", 1, 0, 0);
        chk("sat_val", 64'(stall_cnt), 64'd3);
        cnt_clr = 1'b1;
        tick("clr", 1, 0, 0);
        cnt_clr = 1'b0;
        tick("after_clr", 1, 0, 0);
        set_fwd(0, 0, 0, 5'd0, 32'h0);

        // reset mid-operation
        out_rdy = 1'b0;
        p1      = 32'hD1;
        tick("pre_rst", 0, 32'h0, 32'hD1);
        rst_n  = 1'b0;
        in_vld = 1'b0;
        @(negedge clk);
        chk("mrst_vld", 64'(out_vld), 64'd0);
        chk("mrst_s1", 64'(src1_q), 64'd0);
        chk("mrst_cnt", 64'(stall_cnt), 64'd0);
        sb.delete();
        m_vld   = 1'b0;
        m_cnt   = '0;
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        tick("end", 0, 0, 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
